// File: rtl/stoch_decode_pkg.sv
// stoch_decode_pkg: shared state encoding and width helper for the stochastic decoder
package stoch_decode_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, HOLD} state_t;
  function automatic int cnt_w(input int win_bits);
    return win_bits + 1;
  endfunction
endpackage

// File: rtl/stoch_ones_counter.sv
// stoch_ones_counter: per-element ones counter with clear priority over enable
module stoch_ones_counter
  import stoch_decode_pkg::*;
#(
  parameter int WIN_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr,
  input  logic                en,
  input  logic                bit_in,
  output logic [WIN_BITS:0]   count
);
  localparam int CW = cnt_w(WIN_BITS);
  logic [CW-1:0] count_q, count_d;
  // next count: clear wins, otherwise add the sampled bit while enabled
  always_comb count_d = clr ? '0 : en ? count_q + CW'(bit_in) : count_q;
  // count register
  always_ff @(posedge CLK or posedge RST)
    if (RST) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/stoch_matrix_decode.sv
// stoch_matrix_decode: counts ones of a bitstream matrix over a 2^WIN_BITS window
module stoch_matrix_decode
  import stoch_decode_pkg::*;
#(
  parameter int NUM_ROWS      = 2,
  parameter int NUM_COLS      = 2,
  parameter int WIN_BITS      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic                                       start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]          Y_in,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_BITS:0] count
);
  localparam int SL = SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0;
  localparam int SW = SL > 0 ? $clog2(SL + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SL[SW-1:0];
  state_t state_q, state_d;
  logic [WIN_BITS-1:0] win_q, win_d;
  logic [SW-1:0] settle_q, settle_d;
  logic go, en;
  // a new conversion may start from IDLE or on the HOLD handshake edge
  always_comb go = start && (state_q == IDLE || (state_q == HOLD && out_ready));
  // FSM with settle and window counters; the window wraps to zero on its last edge
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    settle_d = settle_q;
    case (state_q)
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) state_d = ACCUM;
      end
      ACCUM: begin
        win_d = win_q + 1'b1;
        if (&win_q) state_d = HOLD;
      end
      default: begin
        if (go) begin
          state_d = SETTLE_CYCLES > 0 ? SETTLE : ACCUM;
          settle_d = '0;
          win_d = '0;
        end else if (state_q == HOLD && out_ready) state_d = IDLE;
      end
    endcase
  end
  // control state registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      win_q <= '0;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      settle_q <= settle_d;
    end
  assign en = state_q == ACCUM;
  assign busy = state_q == SETTLE || state_q == ACCUM;
  assign out_valid = state_q == HOLD;
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
      stoch_ones_counter #(.WIN_BITS(WIN_BITS)) u_cnt (
        .CLK(CLK),
        .RST(RST),
        .clr(go),
        .en(en),
        .bit_in(Y_in[i][j]),
        .count(count[i][j])
      );
    end
  end
endmodule

// File: tb/tb_stoch_matrix_decode.sv
// tb_stoch_matrix_decode: directed checks of the stochastic matrix decoder
module tb_stoch_matrix_decode;
  logic clk = 1'b0;
  logic rst, start, ready, start2, ready2;
  logic [1:0][1:0] y, y2;
  logic busy, valid, busy2, valid2;
  logic [1:0][1:0][4:0] cnt;
  logic [1:0][1:0][1:0] cnt2;
  int vecs = 0;
  int errs = 0;
  logic bad;

  always #5 clk = ~clk;

  stoch_matrix_decode #(.NUM_ROWS(2), .NUM_COLS(2), .WIN_BITS(4), .SETTLE_CYCLES(2)) dut (
    .CLK(clk), .RST(rst), .start(start), .Y_in(y), .busy(busy),
    .out_valid(valid), .out_ready(ready), .count(cnt)
  );

  stoch_matrix_decode #(.NUM_ROWS(2), .NUM_COLS(2), .WIN_BITS(1), .SETTLE_CYCLES(0)) dut2 (
    .CLK(clk), .RST(rst), .start(start2), .Y_in(y2), .busy(busy2),
    .out_valid(valid2), .out_ready(ready2), .count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; y = '0;
    start2 = 1'b0; ready2 = 1'b0; y2 = '0;
    #12;
    chk("reset_bv", {30'd0, busy, valid}, 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_bv2", {30'd0, busy2, valid2}, 32'd0);
    rst = 1'b0;
    // all ones, S=2, N=16, consumer always ready
    y = '1; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_e0", {30'd0, busy, valid}, 32'd2);
    for (int e = 1; e <= 17; e++) begin
      tick();
      chk("t1_busy", {30'd0, busy, valid}, 32'd2);
    end
    tick();
    chk("t1_hold_bv", {30'd0, busy, valid}, 32'd1);
    chk("t1_cnt", 32'(cnt), 32'({5'd16, 5'd16, 5'd16, 5'd16}));
    tick();
    chk("t1_idle_bv", {30'd0, busy, valid}, 32'd0);
    chk("t1_idle_cnt", 32'(cnt), 32'({5'd16, 5'd16, 5'd16, 5'd16}));
    // mixed pattern, noisy settle, then backpressure
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; y = 4'b1111;
    tick();
    y = 4'b0000;
    tick();
    for (int m = 0; m < 16; m++) begin
      y = {1'b0, 1'b1, 1'b1, (m % 2 == 0)};
      tick();
    end
    chk("t2_hold_bv", {30'd0, busy, valid}, 32'd1);
    chk("t2_cnt", 32'(cnt), 32'({5'd0, 5'd16, 5'd16, 5'd8}));
    for (int b = 0; b < 10; b++) begin
      y = 4'(b);
      tick();
      chk("t2_bp_valid", {31'd0, valid}, 32'd1);
      chk("t2_bp_cnt", 32'(cnt), 32'({5'd0, 5'd16, 5'd16, 5'd8}));
    end
    ready = 1'b1;
    tick();
    chk("t2_accept_bv", {30'd0, busy, valid}, 32'd0);
    ready = 1'b0;
    // back-to-back: restart on the handshake edge
    y = '1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(18);
    chk("t3_hold1_bv", {30'd0, busy, valid}, 32'd1);
    chk("t3_cnt1", 32'(cnt), 32'({5'd16, 5'd16, 5'd16, 5'd16}));
    start = 1'b1; ready = 1'b1; y = '0;
    tick();
    start = 1'b0;
    chk("t3_b2b_bv", {30'd0, busy, valid}, 32'd2);
    chk("t3_b2b_clr", 32'(cnt), 32'd0);
    tick(18);
    chk("t3_hold2_bv", {30'd0, busy, valid}, 32'd1);
    chk("t3_cnt2", 32'(cnt), 32'd0);
    tick();
    chk("t3_idle_bv", {30'd0, busy, valid}, 32'd0);
    // start pulses while busy are ignored
    ready = 1'b0; y = '1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    for (int m = 0; m < 16; m++) begin
      start = (m % 3 == 0);
      tick();
    end
    start = 1'b0;
    chk("t4_hold_bv", {30'd0, busy, valid}, 32'd1);
    chk("t4_cnt", 32'(cnt), 32'({5'd16, 5'd16, 5'd16, 5'd16}));
    ready = 1'b1;
    tick();
    bad = 1'b0;
    for (int m = 0; m < 25; m++) begin
      bad = bad | busy | valid;
      tick();
    end
    chk("t4_single_result", {31'd0, bad}, 32'd0);
    // asynchronous reset mid-accumulation
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(8);
    chk("t4_pre_rst_busy", {30'd0, busy, valid}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_bv", {30'd0, busy, valid}, 32'd0);
    chk("t4_rst_cnt", 32'(cnt), 32'd0);
    tick();
    rst = 1'b0;
    y = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    tick(17);
    chk("t4_not_yet", {31'd0, valid}, 32'd0);
    tick();
    chk("t4_full_bv", {30'd0, busy, valid}, 32'd1);
    chk("t4_full_cnt", 32'(cnt), 32'({5'd0, 5'd16, 5'd0, 5'd16}));
    ready = 1'b1;
    tick();
    // minimum corner: S=0, N=2
    y2 = '1; ready2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t5_e0_bv", {30'd0, busy2, valid2}, 32'd2);
    tick();
    chk("t5_e1_bv", {30'd0, busy2, valid2}, 32'd2);
    tick();
    chk("t5_e2_bv", {30'd0, busy2, valid2}, 32'd1);
    chk("t5_cnt", 32'(cnt2), 32'({2'd2, 2'd2, 2'd2, 2'd2}));
    tick();
    chk("t5_idle_bv", {30'd0, busy2, valid2}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/stoch_matrix_decode.md
Name: stoch_matrix_decode

Overview:
- Downstream stage of the stochastic matrix multiplier.
- Converts its NUM_ROWS x NUM_COLS output bitstreams back to binary by counting ones over a fixed window of 2^WIN_BITS cycles, after an optional settle period that discards pipeline warm-up.
- Presents the resulting count matrix to a binary consumer over a valid/ready handshake.

Parameters:
- NUM_ROWS, 2, rows of the bitstream matrix.
- NUM_COLS, 2, columns of the bitstream matrix.
- WIN_BITS, 8, log2 of the accumulation window; N = 2^WIN_BITS cycles.
- SETTLE_CYCLES, 4, cycles discarded after start before accumulation begins; 0 is legal.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  begin a conversion; sampled only in IDLE, or in HOLD on the handshake cycle.
- Y_in  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  stochastic bitstreams from the matrix multiplier.
- busy  output  1  high in SETTLE and ACCUM.
- out_valid  output  1  count matrix valid; high only in HOLD.
- out_ready  input  1  consumer accepts the count matrix.
- count  output  [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_BITS:0]  ones count per element; range 0..N.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, out_valid=0, all count=0, window and settle counters=0.
- FSM states: IDLE, SETTLE, ACCUM, HOLD.
- IDLE:
  - start=1 at edge k: clear all element counters.
  - Go to SETTLE if SETTLE_CYCLES>0, else ACCUM.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES edges; Y_in ignored.
  - Then go to ACCUM.
- ACCUM:
  - Y_in sampled on exactly N consecutive edges: k+S+1 .. k+S+N, where S=SETTLE_CYCLES.
  - Each element counter increments by Y_in[i][j] on each of these edges.
  - Window counter is WIN_BITS wide.
  - Exit on the edge where the window counter equals N-1. That same edge performs the final increment and moves to HOLD.
- HOLD:
  - out_valid=1, visible after edge k+S+N.
  - count is held stable while out_valid=1 and out_ready=0.
  - Handshake completes on an edge with out_valid=1 and out_ready=1.
  - On that edge: if start=1, clear counters and go directly to SETTLE/ACCUM (back-to-back, no idle bubble); else go to IDLE.
- Output holding: count keeps its last value in IDLE. It is cleared only when a new conversion starts.
- Width rule: counter is WIN_BITS+1 bits, so an all-ones stream yields exactly N with no wrap. Overflow is impossible by construction.
- start while busy or in HOLD without handshake: ignored, not queued.
- out_ready is don't-care outside HOLD.
- RST mid-SETTLE/ACCUM/HOLD: immediate abort to reset values. A partial count is never presented.
- busy and out_valid are never simultaneously high.

Decomposition:
- Shared package stoch_decode_pkg:
  - typedef enum logic [1:0] for state {IDLE, SETTLE, ACCUM, HOLD}.
  - Localparam helper for the count width (WIN_BITS+1).
- Sub-module stoch_ones_counter:
  - One instance per element, generated over NUM_ROWS x NUM_COLS.
  - Inputs: CLK, RST, clr, en, bit.
  - Output: count [WIN_BITS:0].
  - Async-reset register; clr has priority over en.
- Top level holds the FSM, window counter and settle counter, and drives clr/en to all instances.

Test Plan:
- WIN_BITS=4, SETTLE_CYCLES=2, Y_in all ones, start pulse at edge 0, out_ready=1 -> out_valid after edge 18; every count=16; busy high edges 1..18.
- Y_in[0][0] alternating 1,0 (phase starting 1 in ACCUM), Y_in[1][1]=0, others=1, WIN_BITS=4 -> count[0][0]=8, count[1][1]=0, others 16. Y_in toggling during SETTLE does not affect counts.
- Backpressure: out_ready=0 for 10 cycles in HOLD while Y_in changes -> out_valid stays 1 and count constant; accepted on the first out_ready=1 edge, then IDLE.
- Back-to-back: start=1 and out_ready=1 on the same HOLD edge -> busy=1 on the next cycle, counters cleared, second result correct (e.g. all zeros -> 0).
- start pulses during ACCUM -> ignored; exactly one result. RST asserted mid-ACCUM -> out_valid, busy and count go to 0 immediately; the next start gives a full-window result.
- SETTLE_CYCLES=0, WIN_BITS=1 -> out_valid after edge 2; all-ones count=2. This is the minimum-size corner case.
